wb_arbiter: RTL and testbench

Writeback arbiter that merges results from `FU_NUM` functional units onto the single physical-register-file writeback port (`wb_valid/wb_pd/wb_data/wb_epoch`). Each FU pushes results into a small private FIFO through a valid/ready handshake. A round-robin arbiter grants one current-epoch result per cycle to a registered writeback output. Results tagged with a stale epoch (pre-mispredict) are discarded in the buffer and never reach the PRF.

---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs merged onto one PRF writeback port.
// Stale-epoch heads are discarded in the buffer; live heads are granted round-robin.
module wb_arbiter #(
    parameter int FU_NUM    = 4,
    parameter int PHYS_REGS = 64,
    parameter int DW        = 32,
    parameter int PHYS_W    = $clog2(PHYS_REGS),
    parameter int DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FU_NUM-1:0]        fu_valid,
    output logic [FU_NUM-1:0]        fu_ready,
    input  logic [FU_NUM*PHYS_W-1:0] fu_pd,
    input  logic [FU_NUM*DW-1:0]     fu_data,
    input  logic [FU_NUM*2-1:0]      fu_epoch,
    input  logic [1:0]               cur_epoch,
    output logic                     wb_valid,
    output logic [PHYS_W-1:0]        wb_pd,
    output logic [DW-1:0]            wb_data,
    output logic [1:0]               wb_epoch,
    output logic [15:0]              drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [FU_NUM-1:0]        push;
    logic [FU_NUM-1:0]        pop;
    logic [FU_NUM-1:0]        live;
    logic [FU_NUM-1:0]        stale;
    logic [FU_NUM*PHYS_W-1:0] head_pd;
    logic [FU_NUM*DW-1:0]     head_data;
    logic [FU_NUM*2-1:0]      head_ep;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [16:0]      drop_sum;
    logic [15:0]      drop_next;

    for (genvar i = 0; i < FU_NUM; i++) begin : g_fifo
        logic [PHYS_W-1:0] q_pd   [DEPTH];
        logic [DW-1:0]     q_data [DEPTH];
        logic [1:0]        q_ep   [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;

        // Ready looks only at the registered count, never at a same-cycle pop.
        assign fu_ready[i] = (count != FULL);
        assign push[i]     = fu_valid[i] && fu_ready[i];
        assign head_pd[i*PHYS_W +: PHYS_W] = q_pd[rd_ptr];
        assign head_data[i*DW +: DW]       = q_data[rd_ptr];
        assign head_ep[i*2 +: 2]           = q_ep[rd_ptr];
        assign live[i]  = (count != '0) && (q_ep[rd_ptr] == cur_epoch);
        assign stale[i] = (count != '0) && (q_ep[rd_ptr] != cur_epoch);

        always_ff @(posedge clk) begin
            if (push[i]) begin
                q_pd[wr_ptr]   <= fu_pd[i*PHYS_W +: PHYS_W];
                q_data[wr_ptr] <= fu_data[i*DW +: DW];
                q_ep[wr_ptr]   <= fu_epoch[i*2 +: 2];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % FU_NUM);
            if (!grant_valid && live[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end

        // Stale heads drain every cycle regardless of who wins the grant.
        pop = stale;
        if (grant_valid) pop[grant_idx] = 1'b1;

        rr_next = rr_ptr;
        if (grant_valid) begin
            if (int'(grant_idx) == FU_NUM - 1) rr_next = '0;
            else                               rr_next = grant_idx + 1'b1;
        end

        drop_sum = {1'b0, drop_count};
        for (int i = 0; i < FU_NUM; i++) begin
            drop_sum = drop_sum + 17'(stale[i]);
        end
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            drop_count <= '0;
            wb_valid   <= 1'b0;
            wb_pd      <= '0;
            wb_data    <= '0;
            wb_epoch   <= '0;
        end else begin
            rr_ptr     <= rr_next;
            drop_count <= drop_next;
            wb_valid   <= grant_valid;
            if (grant_valid) begin
                wb_pd    <= head_pd[grant_idx*PHYS_W +: PHYS_W];
                wb_data  <= head_data[grant_idx*DW +: DW];
                wb_epoch <= head_ep[grant_idx*2 +: 2];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_wb_arbiter;

    localparam int FU_NUM = 4;
    localparam int PHYS_W = 6;
    localparam int DW     = 32;
    localparam int DEPTH  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [FU_NUM-1:0]        fu_valid = '0;
    logic [FU_NUM-1:0]        fu_ready;
    logic [FU_NUM*PHYS_W-1:0] fu_pd = '0;
    logic [FU_NUM*DW-1:0]     fu_data = '0;
    logic [FU_NUM*2-1:0]      fu_epoch = '0;
    logic [1:0]               cur_epoch = '0;
    logic                     wb_valid;
    logic [PHYS_W-1:0]        wb_pd;
    logic [DW-1:0]            wb_data;
    logic [1:0]               wb_epoch;
    logic [15:0]              drop_count;

    wb_arbiter #(.FU_NUM(FU_NUM), .PHYS_REGS(64), .DW(DW), .PHYS_W(PHYS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_pd(fu_pd), .fu_data(fu_data), .fu_epoch(fu_epoch),
        .cur_epoch(cur_epoch),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data), .wb_epoch(wb_epoch),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PHYS_W-1:0] pd;
        logic [DW-1:0]     data;
        logic [1:0]        ep;
    } ent_t;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: one queue per FU, evaluated once per rising edge.
    ent_t mq [FU_NUM][$];
    int   m_rr = 0;
    logic m_wb_valid = 1'b0;
    ent_t m_wb = '0;
    int   m_drops = 0;
    bit   m_acc [FU_NUM];
    bit   m_live [FU_NUM];
    bit   m_stale [FU_NUM];
    int   m_win;
    ent_t m_e;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < FU_NUM; i++) mq[i].delete();
                m_rr = 0; m_wb_valid = 1'b0; m_wb = '0; m_drops = 0;
            end else begin
                m_win = -1;
                for (int i = 0; i < FU_NUM; i++) begin
                    m_acc[i]   = fu_valid[i] && (mq[i].size() < DEPTH);
                    m_live[i]  = (mq[i].size() > 0) && (mq[i][0].ep == cur_epoch);
                    m_stale[i] = (mq[i].size() > 0) && (mq[i][0].ep != cur_epoch);
                end
                for (int k = 0; k < FU_NUM; k++) begin
                    if (m_win < 0 && m_live[(m_rr + k) % FU_NUM]) m_win = (m_rr + k) % FU_NUM;
                end
                for (int i = 0; i < FU_NUM; i++) begin
                    if (m_stale[i]) begin
                        void'(mq[i].pop_front());
                        if (m_drops < 65535) m_drops++;
                    end
                end
                if (m_win >= 0) begin
                    m_wb = mq[m_win].pop_front();
                    m_wb_valid = 1'b1;
                    m_rr = (m_win + 1) % FU_NUM;
                end else begin
                    m_wb_valid = 1'b0;
                end
                for (int i = 0; i < FU_NUM; i++) begin
                    if (m_acc[i]) begin
                        m_e.pd   = fu_pd[i*PHYS_W +: PHYS_W];
                        m_e.data = fu_data[i*DW +: DW];
                        m_e.ep   = fu_epoch[i*2 +: 2];
                        mq[i].push_back(m_e);
                    end
                end
            end
        end
    end

    // Compare process: every falling edge once enabled.
    bit   chk_en = 1'b0;
    ent_t wb_log [$];
    logic [FU_NUM-1:0] m_rdy;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < FU_NUM; i++) m_rdy[i] = (mq[i].size() < DEPTH);
                chk("model_wb_valid", 64'(wb_valid), 64'(m_wb_valid));
                chk("model_wb_bus", 64'({wb_pd, wb_data, wb_epoch}), 64'(m_wb));
                chk("model_drop_count", 64'(drop_count), 64'(m_drops));
                chk("model_fu_ready", 64'(fu_ready), 64'(m_rdy));
                if (wb_valid) wb_log.push_back({wb_pd, wb_data, wb_epoch});
            end
        end
    end

    task automatic set_fu(input int i, input logic v, input logic [PHYS_W-1:0] pd,
                          input logic [DW-1:0] d, input logic [1:0] ep);
        fu_valid[i] = v;
        fu_pd[i*PHYS_W +: PHYS_W] = pd;
        fu_data[i*DW +: DW] = d;
        fu_epoch[i*2 +: 2] = ep;
    endtask

    task automatic clear_fu();
        for (int i = 0; i < FU_NUM; i++) set_fu(i, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        clear_fu();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int nb [FU_NUM];
    int beat [FU_NUM];
    logic [FU_NUM-1:0] rdy_after [64];

    // Each FU streams nb[i] beats (pd = i*16+beat) honouring fu_ready.
    task automatic run_stream(input logic [1:0] ep, input int cycles);
        logic [FU_NUM-1:0] r;
        for (int i = 0; i < FU_NUM; i++) beat[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (beat[i] < nb[i])
                    set_fu(i, 1'b1, PHYS_W'(i*16 + beat[i]), 32'(32'h1000_0000*(i+1) + beat[i]), ep);
                else
                    set_fu(i, 1'b0, '0, '0, '0);
            end
            r = fu_ready;
            @(negedge clk);
            for (int i = 0; i < FU_NUM; i++) if (fu_valid[i] && r[i]) beat[i]++;
            if (c < 64) rdy_after[c] = fu_ready;
        end
        clear_fu();
    endtask

    logic [FU_NUM-1:0] seen_full;
    ent_t q2 [$];

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("reset_wb_bus", 64'({wb_pd, wb_data, wb_epoch}), 64'd0);
        chk("reset_fu_ready", 64'(fu_ready), 64'hF);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single push: visible on wb exactly two edges after acceptance.
        set_fu(0, 1'b1, 6'd5, 32'hDEAD_BEEF, 2'd0);
        @(negedge clk);
        clear_fu();
        chk("single_e1_valid", 64'(wb_valid), 64'd0);
        @(negedge clk);
        chk("single_e2_valid", 64'(wb_valid), 64'd1);
        chk("single_e2_pd", 64'(wb_pd), 64'd5);
        chk("single_e2_data", 64'(wb_data), 64'hDEAD_BEEF);
        @(negedge clk);
        chk("single_e3_valid", 64'(wb_valid), 64'd0);

        // Fairness: all FUs stream from rr_ptr=0.
        do_reset();
        wb_log.delete();
        for (int i = 0; i < FU_NUM; i++) nb[i] = 4;
        run_stream(2'd0, 14);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 8; k++)
            chk("fair_order", (k < wb_log.size()) ? 64'(wb_log[k].pd) : 64'hFFFF, 64'((k % 4)*16 + k/4));
        chk("fair_total", 64'(wb_log.size()), 64'd16);
        seen_full = '0;
        for (int c = 0; c < 14; c++) seen_full = seen_full | ~rdy_after[c];
        chk("fair_ready_drop", 64'(seen_full), 64'hF);

        // Backpressure on FU2 while FU0/FU1 compete.
        do_reset();
        wb_log.delete();
        nb[0] = 4; nb[1] = 4; nb[2] = 3; nb[3] = 0;
        run_stream(2'd0, 10);
        repeat (8) @(negedge clk);
        chk("bp_ready2_after_2nd", 64'(rdy_after[1][2]), 64'd0);
        chk("bp_ready2_held", 64'(rdy_after[2][2]), 64'd0);
        chk("bp_ready2_after_pop", 64'(rdy_after[3][2]), 64'd1);
        q2.delete();
        foreach (wb_log[k]) if (wb_log[k].pd[5:4] == 2'd2) q2.push_back(wb_log[k]);
        chk("bp_fu2_count", 64'(q2.size()), 64'd3);
        for (int k = 0; k < 3; k++)
            chk("bp_fu2_order", (k < q2.size()) ? 64'(q2[k].pd) : 64'hFFFF, 64'(32 + k));

        // Stale drop: FU1 entries of epoch 1 after switch to epoch 2.
        do_reset();
        cur_epoch = 2'd1;
        set_fu(1, 1'b1, 6'd16, 32'h1111_0000, 2'd1);
        @(negedge clk);
        cur_epoch = 2'd2;
        set_fu(1, 1'b1, 6'd17, 32'h1111_0001, 2'd1);
        @(negedge clk);
        clear_fu();
        chk("stale_drop1", 64'(drop_count), 64'd1);
        chk("stale_novalid1", 64'(wb_valid), 64'd0);
        @(negedge clk);
        chk("stale_drop2", 64'(drop_count), 64'd2);
        chk("stale_novalid2", 64'(wb_valid), 64'd0);
        @(negedge clk);
        chk("stale_drop_hold", 64'(drop_count), 64'd2);
        chk("stale_novalid3", 64'(wb_valid), 64'd0);

        // Mixed epoch: FU0 live, FU3 stale in the same cycle.
        set_fu(0, 1'b1, 6'd7, 32'h0000_0007, 2'd2);
        set_fu(3, 1'b1, 6'd48, 32'h0000_0030, 2'd1);
        @(negedge clk);
        clear_fu();
        @(negedge clk);
        chk("mixed_valid", 64'(wb_valid), 64'd1);
        chk("mixed_pd", 64'(wb_pd), 64'd7);
        chk("mixed_drop", 64'(drop_count), 64'd3);
        chk("mixed_ready", 64'(fu_ready), 64'hF);

        // Reset with five buffered entries and a live writeback on the bus.
        for (int i = 0; i < FU_NUM; i++) set_fu(i, 1'b1, PHYS_W'(i*16 + 8), 32'(i), 2'd2);
        @(negedge clk);
        clear_fu();
        set_fu(2, 1'b1, 6'd41, 32'h2, 2'd2);
        set_fu(3, 1'b1, 6'd57, 32'h3, 2'd2);
        @(negedge clk);
        clear_fu();
        chk("pre_rst_valid", 64'(wb_valid), 64'd1);
        chk("pre_rst_pd", 64'(wb_pd), 64'd24);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(wb_valid), 64'd0);
        chk("midrst_bus", 64'({wb_pd, wb_data, wb_epoch}), 64'd0);
        chk("midrst_ready", 64'(fu_ready), 64'hF);
        chk("midrst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("postrst_quiet", 64'(wb_valid), 64'd0);
        end

        // Drop counter saturation: every FU streams stale results.
        do_reset();
        cur_epoch = 2'd0;
        for (int i = 0; i < FU_NUM; i++) set_fu(i, 1'b1, PHYS_W'(i), 32'(i), 2'd3);
        repeat (16400) @(negedge clk);
        clear_fu();
        chk("sat_drop", 64'(drop_count), 64'hFFFF);
        @(negedge clk);
        chk("sat_drop_hold", 64'(drop_count), 64'hFFFF);
        chk("sat_novalid", 64'(wb_valid), 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
